// File: rtl/arya_pkg.sv
// Shared constants for the register file slice: default datapath and address widths.
// Imported by regfile_mp (which optionally supports the REGFILE_BYPASS_EN build macro) and regfile_scoreboard.
package arya_pkg;

    localparam int INST_WIDTH     = 32;
    localparam int DATAPATH_WIDTH = 64;
    localparam int REGFILE_ADDR   = 3;
    localparam int REGFILE_DEPTH  = 1 << REGFILE_ADDR;

    typedef logic [DATAPATH_WIDTH-1:0] word_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one reservation bit per register file entry.
// Reservations set a bit, writes clear it, clr wipes everything.
module regfile_scoreboard
    import arya_pkg::*;
#(
    parameter int AW = REGFILE_ADDR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rsv_en_i,
    input  logic [AW-1:0]        rsv_addr_i,
    input  logic                 wclr0_en_i,
    input  logic [AW-1:0]        wclr0_addr_i,
    input  logic                 wclr1_en_i,
    input  logic [AW-1:0]        wclr1_addr_i,
    input  logic                 clr_i,
    output logic [(1<<AW)-1:0]   busy_o
);

    localparam int DEPTH = 1 << AW;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;

    // Reservation is applied after the write clears so a same-cycle reserve wins.
    always_comb begin
        busy_d = busy_q;
        if (wclr0_en_i) busy_d[wclr0_addr_i] = 1'b0;
        if (wclr1_en_i) busy_d[wclr1_addr_i] = 1'b0;
        if (rsv_en_i)   busy_d[rsv_addr_i]   = 1'b1;
        if (clr_i)      busy_d               = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with per-entry busy bits and optional hardwired-zero entry 0.
// Define REGFILE_BYPASS_EN to forward same-cycle write data (and a cleared busy) to matching read ports.
module regfile_mp
    import arya_pkg::*;
#(
    parameter int DW      = DATAPATH_WIDTH,
    parameter int AW      = REGFILE_ADDR,
    parameter int NRD     = 2,
    parameter bit R0_ZERO = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*DW-1:0]   rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                wena0,
    input  logic [AW-1:0]       waddr0,
    input  logic [DW-1:0]       wdata0,
    input  logic                wena1,
    input  logic [AW-1:0]       waddr1,
    input  logic [DW-1:0]       wdata1,
    input  logic                rsv_en,
    input  logic [AW-1:0]       rsv_addr
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DW-1:0]    mem_d [DEPTH];
    logic [DEPTH-1:0] busy;
    logic             we0;
    logic             we1;
    logic             rsvEn;

    // With R0_ZERO, anything aimed at entry 0 is dropped before it reaches state.
    assign we0   = wena0  && !(R0_ZERO && (waddr0   == '0));
    assign we1   = wena1  && !(R0_ZERO && (waddr1   == '0));
    assign rsvEn = rsv_en && !(R0_ZERO && (rsv_addr == '0));

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            mem_d[j] = clr ? '0 : mem_q[j];
        end
        if (!clr) begin
            if (we0) mem_d[waddr0] = wdata0;
            if (we1) mem_d[waddr1] = wdata1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem_q[j] <= '0;
            end
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                mem_q[j] <= mem_d[j];
            end
        end
    end

    regfile_scoreboard #(.AW(AW)) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .rsv_en_i     (rsvEn),
        .rsv_addr_i   (rsv_addr),
        .wclr0_en_i   (we0),
        .wclr0_addr_i (waddr0),
        .wclr1_en_i   (we1),
        .wclr1_addr_i (waddr1),
        .clr_i        (clr),
        .busy_o       (busy)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] rdAddr;
        logic [DW-1:0] rdSel;
        logic          rbSel;

        assign rdAddr = raddr[i*AW +: AW];

        // Reset gating is explicit so bypassed data cannot leak out while reset is held.
        always_comb begin
            rdSel = mem_q[rdAddr];
            rbSel = busy[rdAddr];
`ifdef REGFILE_BYPASS_EN
            if (we1 && (waddr1 == rdAddr)) begin
                rdSel = wdata1;
                rbSel = 1'b0;
            end else if (we0 && (waddr0 == rdAddr)) begin
                rdSel = wdata0;
                rbSel = 1'b0;
            end
`endif
            if (R0_ZERO && (rdAddr == '0)) begin
                rdSel = '0;
                rbSel = 1'b0;
            end
            if (!reset) begin
                rdSel = '0;
                rbSel = 1'b0;
            end
        end

        assign rdata[i*DW +: DW] = rdSel;
        assign rbusy[i]          = rbSel;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: one default instance and one R0_ZERO instance share all inputs.
// Expected read values come from a plain array model of the entries and busy bits.
module tb_regfile_mp;

    localparam int DW    = 64;
    localparam int AW    = 3;
    localparam int NRD   = 2;
    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              clr = 1'b0;
    logic [NRD*AW-1:0] raddr = '0;
    logic              wena0 = 1'b0;
    logic [AW-1:0]     waddr0 = '0;
    logic [DW-1:0]     wdata0 = '0;
    logic              wena1 = 1'b0;
    logic [AW-1:0]     waddr1 = '0;
    logic [DW-1:0]     wdata1 = '0;
    logic              rsv_en = 1'b0;
    logic [AW-1:0]     rsv_addr = '0;

    logic [NRD*DW-1:0] rdataN;
    logic [NRD-1:0]    rbusyN;
    logic [NRD*DW-1:0] rdataZ;
    logic [NRD-1:0]    rbusyZ;

    always #5 clk = ~clk;

    regfile_mp #(.DW(DW), .AW(AW), .NRD(NRD), .R0_ZERO(1'b0)) dut (
        .clk(clk), .reset(reset), .clr(clr), .raddr(raddr), .rdata(rdataN), .rbusy(rbusyN),
        .wena0(wena0), .waddr0(waddr0), .wdata0(wdata0),
        .wena1(wena1), .waddr1(waddr1), .wdata1(wdata1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    regfile_mp #(.DW(DW), .AW(AW), .NRD(NRD), .R0_ZERO(1'b1)) dutZ (
        .clk(clk), .reset(reset), .clr(clr), .raddr(raddr), .rdata(rdataZ), .rbusy(rbusyZ),
        .wena0(wena0), .waddr0(waddr0), .wdata0(wdata0),
        .wena1(wena1), .waddr1(waddr1), .wdata1(wdata1),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr)
    );

    typedef struct {
        string             tag;
        logic [NRD*DW-1:0] dN;
        logic [NRD-1:0]    bN;
        logic [NRD*DW-1:0] dZ;
        logic [NRD-1:0]    bZ;
    } exp_t;

    logic [DW-1:0] refMem  [2][DEPTH];
    bit            refBusy [2][DEPTH];
    exp_t          sbq[$];
    int            checks = 0;
    int            errors = 0;

    function automatic void refClear();
        for (int v = 0; v < 2; v++)
            for (int j = 0; j < DEPTH; j++) begin
                refMem[v][j]  = '0;
                refBusy[v][j] = 1'b0;
            end
    endfunction

    // Variant 1 models R0_ZERO: entry 0 always reads zero and is never busy.
    function automatic void refRead(input int v, input int a, output logic [DW-1:0] d, output logic b);
        d = refMem[v][a];
        b = refBusy[v][a];
`ifdef REGFILE_BYPASS_EN
        if (wena1 && int'(waddr1) == a) begin
            d = wdata1;
            b = 1'b0;
        end else if (wena0 && int'(waddr0) == a) begin
            d = wdata0;
            b = 1'b0;
        end
`endif
        if (v == 1 && a == 0) begin
            d = '0;
            b = 1'b0;
        end
        if (!reset) begin
            d = '0;
            b = 1'b0;
        end
    endfunction

    function automatic void refCommit();
        if (!reset) return;
        if (clr) begin
            refClear();
            return;
        end
        for (int v = 0; v < 2; v++) begin
            if (wena0 && !(v == 1 && waddr0 == 0)) begin
                refMem[v][waddr0]  = wdata0;
                refBusy[v][waddr0] = 1'b0;
            end
            if (wena1 && !(v == 1 && waddr1 == 0)) begin
                refMem[v][waddr1]  = wdata1;
                refBusy[v][waddr1] = 1'b0;
            end
            if (rsv_en && !(v == 1 && rsv_addr == 0))
                refBusy[v][rsv_addr] = 1'b1;
        end
    endfunction

    // Inputs are already driven (posedge+1); push the expectation, then advance one cycle.
    task automatic applyStimulus(input string tag);
        exp_t          e;
        logic [DW-1:0] d;
        logic          b;
        if (!reset) refClear();
        e.tag = tag;
        for (int p = 0; p < NRD; p++) begin
            refRead(0, int'(raddr[p*AW +: AW]), d, b);
            e.dN[p*DW +: DW] = d;
            e.bN[p] = b;
            refRead(1, int'(raddr[p*AW +: AW]), d, b);
            e.dZ[p*DW +: DW] = d;
            e.bZ[p] = b;
        end
        sbq.push_back(e);
        @(posedge clk);
        refCommit();
        #1;
    endtask

    task automatic checkOutput(input exp_t e);
        for (int p = 0; p < NRD; p++) begin
            checks += 4;
            if (rdataN[p*DW +: DW] !== e.dN[p*DW +: DW]) begin
                errors++;
                $display("[TB] FAIL %s dut port%0d rdata actual %h required %h", e.tag, p, rdataN[p*DW +: DW], e.dN[p*DW +: DW]);
            end
            if (rbusyN[p] !== e.bN[p]) begin
                errors++;
                $display("[TB] FAIL %s dut port%0d rbusy actual %b required %b", e.tag, p, rbusyN[p], e.bN[p]);
            end
            if (rdataZ[p*DW +: DW] !== e.dZ[p*DW +: DW]) begin
                errors++;
                $display("[TB] FAIL %s dutZ port%0d rdata actual %h required %h", e.tag, p, rdataZ[p*DW +: DW], e.dZ[p*DW +: DW]);
            end
            if (rbusyZ[p] !== e.bZ[p]) begin
                errors++;
                $display("[TB] FAIL %s dutZ port%0d rbusy actual %b required %b", e.tag, p, rbusyZ[p], e.bZ[p]);
            end
        end
    endtask

    // Monitor: outputs are combinational, so every negedge presents one response to score.
    always @(negedge clk) begin
        if (sbq.size() != 0) checkOutput(sbq.pop_front());
    end

    task automatic setIdle();
        wena0  = 1'b0;
        wena1  = 1'b0;
        rsv_en = 1'b0;
        clr    = 1'b0;
    endtask

    task automatic setRead(input int a0, input int a1);
        raddr = {AW'(a1), AW'(a0)};
    endtask

    task automatic setW0(input int a, input logic [DW-1:0] d);
        wena0 = 1'b1; waddr0 = AW'(a); wdata0 = d;
    endtask

    task automatic setW1(input int a, input logic [DW-1:0] d);
        wena1 = 1'b1; waddr1 = AW'(a); wdata1 = d;
    endtask

    task automatic setRsv(input int a);
        rsv_en = 1'b1; rsv_addr = AW'(a);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired, checks %0d errors %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        refClear();
        @(posedge clk);
        #1;
        setRead(0, 7); applyStimulus("resetHeld");
        setRead(3, 5); applyStimulus("resetHeld");
        reset = 1'b1;

        for (int a = 1; a < DEPTH; a++) begin
            setW0(a, 64'hA5); setRead(a, a - 1);
            applyStimulus("fillA5");
        end
        setIdle(); setRead(1, 7); applyStimulus("readA5");

        setW0(2, 64'h1234); setRsv(3); reset = 1'b0; setRead(1, 7);
        applyStimulus("resetMid");
        reset = 1'b1; setIdle();
        for (int a = 0; a < DEPTH; a += 2) begin
            setRead(a, a + 1); applyStimulus("afterReset");
        end

        setW0(3, 64'h11); setW1(3, 64'h22); setRead(3, 3); applyStimulus("dualWrite");
        setIdle(); applyStimulus("dualWriteRead");

        setRsv(5); setRead(5, 0); applyStimulus("rsv5");
        setIdle(); setRead(5, 5); applyStimulus("rsv5Busy");
        setW0(5, 64'h5555); applyStimulus("write5");
        setIdle(); applyStimulus("write5Read");

        setW1(2, 64'hBEEF); setRead(2, 2); applyStimulus("sameCycle2");
        setIdle(); applyStimulus("sameCycle2Read");

        setW0(0, 64'hFF); setRsv(0); setRead(0, 1); applyStimulus("r0Write");
        setIdle(); applyStimulus("r0Read");

        setW0(6, 64'h66); setRsv(6); setRead(6, 0); applyStimulus("rsvWins");
        setIdle(); setRead(6, 6); applyStimulus("rsvWinsRead");

        setRsv(1); applyStimulus("rsv1");
        setRsv(7); applyStimulus("rsv7");
        clr = 1'b1; setW0(4, 64'h77); setRsv(2); setRead(4, 1); applyStimulus("clrWrite");
        setIdle(); setRead(4, 2); applyStimulus("clrRead");
        setRead(7, 6); applyStimulus("clrRead");

        for (int n = 0; n < 400; n++) begin
            reset  = ($urandom_range(0, 49) != 0);
            clr    = ($urandom_range(0, 19) == 0);
            wena0  = $urandom_range(0, 1) == 1;
            waddr0 = AW'($urandom_range(0, DEPTH - 1));
            wdata0 = {$urandom, $urandom};
            wena1  = $urandom_range(0, 2) == 0;
            waddr1 = AW'($urandom_range(0, DEPTH - 1));
            wdata1 = {$urandom, $urandom};
            rsv_en = $urandom_range(0, 2) == 0;
            rsv_addr = AW'($urandom_range(0, DEPTH - 1));
            setRead($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
            applyStimulus("random");
        end

        setIdle();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain pending actual %0d required 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DW, default 64: data width in bits.
REQ-002 SHALL have parameter AW, default 3: address width; depth = 2**AW entries.
REQ-003 SHALL have parameter NRD, default 2: number of read ports.
REQ-004 SHALL have parameter R0_ZERO, default 0: when 1, entry 0 reads as zero and ignores writes.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port clr  input  1  synchronous clear of all entries and busy bits.
REQ-008 SHALL have port raddr  input  NRD*AW  read addresses; port i at bits [i*AW +: AW].
REQ-009 SHALL have port rdata  output  NRD*DW  read data; port i at bits [i*DW +: DW].
REQ-010 SHALL have port rbusy  output  NRD  port i: addressed entry has an outstanding reservation.
REQ-011 SHALL have ports wena0/wena1  input  1  write enables, write ports 0 and 1.
REQ-012 SHALL have ports waddr0/waddr1  input  AW  write addresses.
REQ-013 SHALL have ports wdata0/wdata1  input  DW  write data.
REQ-014 SHALL have ports rsv_en  input  1  and rsv_addr  input  AW  to reserve an entry (mark busy).

Function
REQ-015 SHALL return rdata[i] = entry[raddr[i]] combinationally, zero read latency.
REQ-016 SHALL update an entry on the rising edge after its wena is sampled high (1-cycle write latency).
REQ-017 SHALL, on wena0 and wena1 to the same address in one cycle, store wdata1 (port 1 wins).
REQ-018 SHALL hold one busy bit per entry; rsv_en sets busy[rsv_addr] on the next edge.
REQ-019 SHALL clear busy[waddrN] on the next edge after any write to that address.
REQ-020 SHALL, on rsv_en and a write to the same address in one cycle, perform the write and leave busy set (the reservation wins).
REQ-021 SHALL drive rbusy[i] = busy[raddr[i]] combinationally.
REQ-022 SHALL, with R0_ZERO=1, drive rdata=0 and rbusy=0 for address 0, and ignore writes and reservations to address 0.
REQ-023 SHALL, when clr is high, zero all entries and busy bits on the next edge, overriding any same-cycle write or reservation.
REQ-024 SHALL leave state unchanged in a cycle with no wena, rsv_en or clr.

Reset
REQ-025 SHALL, on reset low, asynchronously zero all entries and all busy bits.
REQ-026 SHALL, while reset is low, drive rdata to 0 and rbusy to 0 on every port.
REQ-027 SHALL discard any write or reservation that coincides with reset assertion.

Configuration
REQ-028 SHALL, with macro REGFILE_BYPASS_EN defined, forward same-cycle write data: when raddr[i] matches an enabled waddr, rdata[i] = that wdata (port 1 before port 0) and rbusy[i] = 0.
REQ-029 SHALL, without REGFILE_BYPASS_EN, return the stored value (pre-write) on a same-cycle read/write address match.

Structure
REQ-030 SHALL take DW/AW defaults and the INST_WIDTH, DATAPATH_WIDTH and REGFILE_ADDR constants from the shared package arya_pkg.
REQ-031 SHALL implement the busy-bit logic in sub-module regfile_scoreboard (parameter AW; inputs: rsv, two write clears, clr; output: busy vector).

Verification
REQ-032 SHALL cover: reset low mid-run after entries 1..7 = 0xA5 -> all rdata = 0 immediately; after release, reads remain 0.
REQ-033 SHALL cover: wena0 and wena1 both to addr 3, wdata0=0x11, wdata1=0x22 -> next-cycle read of addr 3 = 0x22.
REQ-034 SHALL cover: rsv_en addr 5 -> rbusy=1 next cycle; write 0x5555 to addr 5 -> rbusy=0 and rdata=0x5555 the following cycle.
REQ-035 SHALL cover: with REGFILE_BYPASS_EN, write 0xBEEF to addr 2 while reading addr 2 -> rdata=0xBEEF in the same cycle; without the macro -> old value, then 0xBEEF next cycle.
REQ-036 SHALL cover: R0_ZERO=1, write 0xFF to addr 0 -> read addr 0 = 0 and rbusy = 0.
REQ-037 SHALL cover: clr together with write 0x77 to addr 4 -> next cycle: addr 4 = 0 and all rbusy = 0.
